// File: rtl/uart_tx_param.sv
// Framed UART transmitter: start, DATA_BITS LSB-first, optional parity, stop bits.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits.
module uart_tx_param #(
  parameter int CLOCKS_PER_BAUD = 868,
  parameter int CNT_W           = 24,
  parameter int DATA_BITS       = 8,
  parameter int STOP_BITS       = 1,
  parameter int PARITY_ODD      = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_wr,
  input  logic [DATA_BITS-1:0] i_data,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_uart_tx
);

  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLOCKS_PER_BAUD - 1);

  if (CLOCKS_PER_BAUD < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
      STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 ||
      PARITY_ODD > 1 || CLOCKS_PER_BAUD - 1 >= 2**CNT_W) begin : g_bad
    $error("uart_tx_param: illegal parameter set");
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
  } state_t;
`endif

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 baud;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  assign baud = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != IDLE && !baud)
      cnt_d = cnt_q - 1'b1;
    case (state_q)
      IDLE: begin
        if (i_wr) begin
          state_d = START;
          cnt_d   = RELOAD;
          sh_d    = i_data;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_d   = (^i_data) ^ (PARITY_ODD != 0);
`endif
        end
      end
      START: begin
        if (baud) begin
          state_d = DATA;
          cnt_d   = RELOAD;
          tx_d    = sh_q[0];
          sh_d    = {1'b1, sh_q[DATA_BITS-1:1]};
          bit_d   = BW'(1);
        end
      end
      DATA: begin
        if (baud) begin
          cnt_d = RELOAD;
          if (bit_q == BW'(DATA_BITS)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
            bit_d   = BW'(1);
`endif
          end else begin
            tx_d  = sh_q[0];
            sh_d  = {1'b1, sh_q[DATA_BITS-1:1]};
            bit_d = bit_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud) begin
          state_d = STOP;
          cnt_d   = RELOAD;
          tx_d    = 1'b1;
          bit_d   = BW'(1);
        end
      end
`endif
      STOP: begin
        if (baud) begin
          if (bit_q == BW'(STOP_BITS)) begin
            state_d = IDLE;
            cnt_d   = '0;
            bit_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            cnt_d = RELOAD;
            bit_d = bit_q + 1'b1;
          end
          tx_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '1;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_uart_tx = tx_q;

endmodule
